// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for a product-sum accumulator: buffers up to eight {ai, xi}
// pairs, streams them with optional bubbles, flushes the accumulator, captures the sum.
module mac_operand_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [7:0]  wr_ai,
   input  logic [7:0]  wr_xi,
   input  logic [3:0]  count,
   input  logic        start,
   input  logic        pause,
   output logic        mac_enable,
   output logic        mac_valid_in,
   output logic        mac_done,
   output logic [7:0]  mac_ai,
   output logic [7:0]  mac_xi,
   input  logic [15:0] mac_result,
   output logic [15:0] sum,
   output logic        sum_valid,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STREAM  = 2'd1,
      S_FLUSH   = 2'd2,
      S_CAPTURE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  n_q, n_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] buf_q [8];
   logic [15:0] sum_q;
   logic        sum_valid_q;
   logic        last_beat;

   // Entry n-1 is the final beat; n is never 0 while streaming.
   assign last_beat = ({1'b0, idx_q} == (n_q - 4'd1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
      end
   end

   // Host writes land only while idle so an in-flight evaluation sees a stable buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      end else if (wr_en && (state_q == S_IDLE)) begin
         buf_q[wr_addr] <= {wr_ai, wr_xi};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
      end else begin
         sum_valid_q <= (state_q == S_CAPTURE);
         if (state_q == S_CAPTURE) sum_q <= mac_result;
      end
   end

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      idx_d        = idx_q;
      mac_enable   = 1'b0;
      mac_valid_in = 1'b0;
      mac_done     = 1'b0;
      mac_ai       = '0;
      mac_xi       = '0;
      case (state_q)
         S_IDLE: begin
            if (start && (count != 4'd0)) begin
               n_d     = (count > 4'd8) ? 4'd8 : count;
               idx_d   = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            mac_enable = 1'b1;
            if (!pause) begin
               mac_valid_in = 1'b1;
               mac_ai       = buf_q[idx_q][15:8];
               mac_xi       = buf_q[idx_q][7:0];
               idx_d        = idx_q + 3'd1;
               if (last_beat) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            mac_enable = 1'b1;
            mac_done   = 1'b1;
            state_d    = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign sum       = sum_q;
   assign sum_valid = sum_valid_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer paired with a product-sum accumulator model.
module tb_mac_operand_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_ai, wr_xi;
   logic [3:0]  count;
   logic        start, pause;
   logic        mac_enable, mac_valid_in, mac_done;
   logic [7:0]  mac_ai, mac_xi;
   logic [15:0] mac_result;
   logic [15:0] sum;
   logic        sum_valid, busy;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mac_operand_sequencer dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_ai(wr_ai), .wr_xi(wr_xi), .count(count), .start(start), .pause(pause),
      .mac_enable(mac_enable), .mac_valid_in(mac_valid_in), .mac_done(mac_done),
      .mac_ai(mac_ai), .mac_xi(mac_xi), .mac_result(mac_result),
      .sum(sum), .sum_valid(sum_valid), .busy(busy)
   );

   // Product-sum accumulator: disabled clears, valid beats accumulate with 16-bit wrap.
   logic [15:0] acc = '0;
   always @(posedge clk) begin
      if (!mac_enable) acc <= '0;
      else if (mac_valid_in) acc <= acc + ({8'd0, mac_ai} * {8'd0, mac_xi});
   end
   assign mac_result = acc;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Scoreboard: every sum_valid pulse consumes one expected sum.
   always @(negedge clk) begin
      if (sum_valid === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_sum_valid", 32'd1, 32'd0);
         else check("sum", {16'd0, sum}, {16'd0, exp_q.pop_front()});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic write_entry(input logic [2:0] a, input logic [7:0] ai, input logic [7:0] xi);
      wr_en = 1'b1; wr_addr = a; wr_ai = ai; wr_xi = xi;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic start_pulse(input logic [3:0] cnt);
      start = 1'b1; count = cnt;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Cycle k (k>=1) is the cycle after edge k-1; edge 0 sampled start.
   task automatic observe(input logic [31:0] pmask, input bit wr_busy, input bit chain,
                          input logic [3:0] chain_cnt, output int sv_cycle, output int beats,
                          output logic [31:0] busy_mask, output logic [31:0] done_mask,
                          output int bad_pause);
      sv_cycle = -1; beats = 0; busy_mask = '0; done_mask = '0; bad_pause = 0;
      for (int k = 1; k <= 24 && sv_cycle < 0; k++) begin
         pause = pmask[k];
         if (wr_busy && k <= 2) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_ai = 8'd100; wr_xi = 8'd100;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         busy_mask[k] = busy;
         done_mask[k] = mac_done;
         if (mac_valid_in) beats++;
         if (pause && busy && (mac_valid_in || mac_ai != 8'd0 || mac_xi != 8'd0)) bad_pause++;
         if (sum_valid) begin
            sv_cycle = k;
            if (chain) begin
               start = 1'b1; count = chain_cnt;
            end
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      pause = 1'b0;
      wr_en = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int sv, beats, badp;
   logic [31:0] bmask, dmask;

   initial begin
      wr_en = 0; wr_addr = 0; wr_ai = 0; wr_xi = 0;
      count = 0; start = 0; pause = 0;
      do_reset();

      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
      check("rst_mac_ctl", {29'd0, mac_enable, mac_valid_in, mac_done}, 32'd0);
      check("rst_mac_data", {16'd0, mac_ai, mac_xi}, 32'd0);
      @(posedge clk); #1;

      // Basic three-pair evaluation: 6+20+42 = 68
      write_entry(3'd0, 8'd2, 8'd3);
      write_entry(3'd1, 8'd4, 8'd5);
      write_entry(3'd2, 8'd6, 8'd7);
      exp_q.push_back(16'd68);
      start_pulse(4'd3);
      observe(32'h0, 1'b0, 1'b0, 4'd0, sv, beats, bmask, dmask, badp);
      check("basic_sv_cycle", sv, 32'd6);
      check("basic_busy_cycles", bmask, 32'h0000_003E);
      check("basic_beats", beats, 32'd3);
      check("basic_done_cycle", dmask, 32'h0000_0010);

      // Pause in cycles 2,3 (bubbles) and 6 (FLUSH, ignored)
      exp_q.push_back(16'd68);
      start_pulse(4'd3);
      observe(32'h0000_004C, 1'b0, 1'b0, 4'd0, sv, beats, bmask, dmask, badp);
      check("pause_sv_cycle", sv, 32'd8);
      check("pause_beats", beats, 32'd3);
      check("pause_bubbles_quiet", badp, 32'd0);
      check("pause_busy_cycles", bmask, 32'h0000_00FE);
      check("pause_done_cycle", dmask, 32'h0000_0040);

      // Back-to-back: host writes during run A are dropped; run B (count=1) sees entry0=(2,3)
      exp_q.push_back(16'd68);
      exp_q.push_back(16'd6);
      start_pulse(4'd3);
      observe(32'h0, 1'b1, 1'b1, 4'd1, sv, beats, bmask, dmask, badp);
      check("b2b_first_sv_cycle", sv, 32'd6);
      observe(32'h0, 1'b0, 1'b0, 4'd0, sv, beats, bmask, dmask, badp);
      check("b2b_second_sv_cycle", sv, 32'd4);
      check("b2b_second_beats", beats, 32'd1);

      // Eight (255,255) pairs: 520200 mod 65536 = 61448
      for (int i = 0; i < 8; i++) write_entry(i[2:0], 8'd255, 8'd255);
      exp_q.push_back(16'd61448);
      start_pulse(4'd8);
      observe(32'h0, 1'b0, 1'b0, 4'd0, sv, beats, bmask, dmask, badp);
      check("full_sv_cycle", sv, 32'd11);
      check("full_beats", beats, 32'd8);

      // count=12 clamps to 8 beats
      exp_q.push_back(16'd61448);
      start_pulse(4'd12);
      observe(32'h0, 1'b0, 1'b0, 4'd0, sv, beats, bmask, dmask, badp);
      check("clamp_beats", beats, 32'd8);
      check("clamp_sv_cycle", sv, 32'd11);

      // count=0 is ignored
      start_pulse(4'd0);
      observe(32'h0, 1'b0, 1'b0, 4'd0, sv, beats, bmask, dmask, badp);
      check("zero_busy", bmask, 32'd0);
      check("zero_no_sum_valid", sv, 32'hFFFF_FFFF);
      check("zero_sum_held", {16'd0, sum}, 32'd61448);

      // Reset in the 2nd STREAM cycle aborts without a sum_valid pulse
      start_pulse(4'd8);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_mac_enable", {31'd0, mac_enable}, 32'd0);
      check("abort_sum_cleared", {16'd0, sum}, 32'd0);
      repeat (12) @(posedge clk);
      #1;

      // Fresh run after abort: no stale accumulator or buffer content
      write_entry(3'd0, 8'd9, 8'd9);
      exp_q.push_back(16'd81);
      start_pulse(4'd1);
      observe(32'h0, 1'b0, 1'b0, 4'd0, sv, beats, bmask, dmask, badp);
      check("post_reset_sv_cycle", sv, 32'd4);
      exp_q.push_back(16'd81);
      start_pulse(4'd2);
      observe(32'h0, 1'b0, 1'b0, 4'd0, sv, beats, bmask, dmask, badp);
      check("post_reset_buf_cleared_sv", sv, 32'd5);

      repeat (3) @(posedge clk);
      check("scoreboard_drain", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
